uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 169 ++++++++++++++++
 tb/tb_uart_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small transmit FIFO.
//
// Bytes are accepted through a valid/ready handshake into a FIFO, then
// serialized LSB first as start(0), 8 data bits, stop(1). Each line bit
// lasts CLKS_PER_BIT = CLK_HZ/BAUD clock cycles. Queued bytes follow each
// other with no idle gap between frames.
//
// Ports
//   CLK       in   system clock, rising edge
//   rst       in   synchronous reset, active-high
//   tx_data   in   [7:0] byte to transmit
//   tx_valid  in   tx_data is valid
//   tx_ready  out  FIFO can accept a byte
//   TX        out  serial line, idle high (registered)
//   tx_busy   out  frame in progress or FIFO non-empty
module uart_tx #(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       TX,
   output logic       tx_busy
);

   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [NW-1:0] COUNT_FULL = NW'(FIFO_DEPTH);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLK_HZ/BAUD must be at least 2");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx: FIFO_DEPTH must be a power of two in 2..16");
   end

   // ---------------------------------------------------------------- FIFO
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [NW-1:0] count;
   logic          push, pop, fifo_empty;

   assign tx_ready   = (count != COUNT_FULL);
   assign fifo_empty = (count == '0);
   assign push       = tx_valid && tx_ready;

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge CLK) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= tx_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + NW'(1);
            2'b01:   count <= count - NW'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------- serializer
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [2:0]    bit_idx, bit_idx_next;
   logic [7:0]    shift, shift_next;
   logic          tx_next;
   logic          bit_done;

   assign tx_busy = (state != IDLE) || !fifo_empty;

   always_ff @(posedge CLK) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         TX      <= 1'b1;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_idx <= bit_idx_next;
         shift   <= shift_next;
         TX      <= tx_next;
      end
   end

   // TX is registered from the value the line must carry in the next state,
   // so the start bit appears on the edge right after the pop.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      bit_idx_next = bit_idx;
      shift_next   = shift;
      tx_next      = TX;
      pop          = 1'b0;
      bit_done     = (cnt == CNT_LAST);

      if (state != IDLE) begin
         cnt_next = bit_done ? '0 : cnt + CW'(1);
      end

      case (state)
         IDLE: begin
            tx_next = 1'b1;
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_next = mem[rd_ptr];
               cnt_next   = '0;
               state_next = START;
               tx_next    = 1'b0;
            end
         end
         START: begin
            if (bit_done) begin
               state_next   = DATA;
               bit_idx_next = '0;
               tx_next      = shift[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_idx == 3'd7) begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end else begin
                  shift_next   = shift >> 1;
                  bit_idx_next = bit_idx + 3'd1;
                  tx_next      = shift[1];
               end
            end
         end
         STOP: begin
            if (bit_done) begin
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  shift_next = mem[rd_ptr];
                  state_next = START;
                  tx_next    = 1'b0;
               end else begin
                  state_next = IDLE;
                  tx_next    = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx.
//
// Accepted bytes (valid && ready at a rising edge, outside reset) are pushed
// into exp_q. A monitor samples the line 1 ns after every rising edge and
// treats the queue as the FIFO contents: a frame must start exactly one edge
// after the queue becomes non-empty while the line is idle, each frame must
// be 10 bit times of start/data/stop, a mid-bit receiver must return the
// byte, tx_ready must equal (queue size < depth) and tx_busy must equal
// (frame in progress or queue non-empty).
`timescale 1ns/1ps
module tb_uart_tx;

   // 1_350_000 / 100_000 = 13.5, truncated to 13 clocks per bit.
   localparam int unsigned CLK_HZ = 1_350_000;
   localparam int unsigned BAUD   = 100_000;
   localparam int unsigned CPB    = 13;
   localparam int unsigned DEPTH  = 4;

   logic       CLK;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       TX;
   logic       tx_busy;

   int unsigned checks;
   int unsigned errors;

   logic [7:0]  exp_q [$];
   bit          mon_en;
   bit          mon_in_frame;
   bit          mon_must_start;
   int unsigned mon_pos;
   int unsigned mon_bad;
   logic [7:0]  mon_cur;
   logic [7:0]  mon_rx;

   uart_tx #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .CLK      (CLK),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .TX       (TX),
      .tx_busy  (tx_busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: bytes accepted and not yet started on the line.
   always @(posedge CLK) begin
      if (rst) begin
         exp_q.delete();
      end else if (tx_valid && tx_ready) begin
         exp_q.push_back(tx_data);
      end
   end

   // Monitor / line receiver.
   initial begin : monitor
      int unsigned b;
      logic        exp_line;
      mon_in_frame   = 1'b0;
      mon_must_start = 1'b0;
      mon_pos        = 0;
      mon_bad        = 0;
      mon_cur        = '0;
      mon_rx         = '0;
      forever begin
         @(posedge CLK);
         #1;
         if (mon_en) begin
            if (rst) begin
               mon_in_frame   = 1'b0;
               mon_must_start = 1'b0;
               check("reset_tx", TX, 1);
               check("reset_busy", tx_busy, 0);
               check("reset_ready", tx_ready, 1);
            end else begin
               if (!mon_in_frame) begin
                  check("start_timing", (TX === 1'b0), mon_must_start);
                  if (TX === 1'b0) begin
                     check("frame_expected", (exp_q.size() != 0), 1);
                     if (exp_q.size() != 0) begin
                        mon_cur      = exp_q.pop_front();
                        mon_in_frame = 1'b1;
                        mon_pos      = 0;
                        mon_bad      = 0;
                        mon_rx       = '0;
                     end
                  end
               end
               check("busy", tx_busy, (mon_in_frame || exp_q.size() != 0));
               check("ready", tx_ready, (exp_q.size() < DEPTH));
               if (mon_in_frame) begin
                  b = mon_pos / CPB;
                  exp_line = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : mon_cur[b-1];
                  if (TX !== exp_line) mon_bad++;
                  if (b >= 1 && b <= 8 && (mon_pos % CPB) == CPB / 2) mon_rx[b-1] = TX;
                  mon_pos++;
                  if (mon_pos == 10 * CPB) begin
                     check("frame_shape", mon_bad, 0);
                     check("rx_byte", mon_rx, mon_cur);
                     mon_in_frame = 1'b0;
                  end
               end
               mon_must_start = !mon_in_frame && (exp_q.size() != 0);
            end
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic push_byte(input logic [7:0] d);
      int unsigned waited;
      waited   = 0;
      tx_data  = d;
      tx_valid = 1'b1;
      while (!tx_ready && waited < 20 * CPB) begin
         @(negedge CLK);
         waited++;
      end
      if (!tx_ready) begin
         check("accept_timeout", tx_ready, 1);
      end
      @(negedge CLK);
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int unsigned n;
      n = 0;
      while (tx_busy !== 1'b0 && n < 120 * CPB) begin
         @(negedge CLK);
         n++;
      end
      check("idle_timeout", tx_busy, 0);
      repeat (3) @(negedge CLK);
   endtask

   initial begin : stimulus
      int unsigned n;
      int unsigned gap;
      checks   = 0;
      errors   = 0;
      mon_en   = 1'b0;
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = '0;
      @(negedge CLK);
      @(negedge CLK);
      mon_en = 1'b1;

      // Bytes offered during reset are dropped.
      tx_valid = 1'b1;
      tx_data  = 8'h99;
      repeat (3) @(negedge CLK);
      tx_valid = 1'b0;
      rst      = 1'b0;
      check("post_reset_tx", TX, 1);
      check("post_reset_busy", tx_busy, 0);
      check("post_reset_ready", tx_ready, 1);
      repeat (5 * CPB) @(negedge CLK);

      // Single byte with exact start latency.
      push_byte(8'h55);
      check("latency_pre", TX, 1);
      @(negedge CLK);
      check("latency_start", TX, 0);
      wait_idle();

      push_byte(8'hA3);
      wait_idle();

      // Four back-to-back bytes: contiguous frames, busy until the last stop ends.
      for (int i = 0; i < 4; i++) push_byte(8'(i + 1));
      n = 0;
      while (tx_busy && n < 60 * CPB) begin
         n++;
         @(negedge CLK);
      end
      check("burst_busy_cycles", n, 40 * CPB - 2);
      wait_idle();

      // Fill the FIFO, then hold a sixth byte until the first frame ends.
      for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i));
      check("full_ready_low", tx_ready, 0);
      tx_data  = 8'h15;
      tx_valid = 1'b1;
      n = 0;
      while (!tx_ready && n < 20 * CPB) begin
         @(negedge CLK);
         n++;
      end
      check("held_wait_cycles", n, 10 * CPB - 3);
      @(negedge CLK);
      tx_valid = 1'b0;
      wait_idle();

      // Random bytes with random spacing.
      for (int i = 0; i < 40; i++) begin
         gap = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 160) : $urandom_range(0, 2);
         repeat (gap) @(negedge CLK);
         push_byte(8'($urandom));
      end
      wait_idle();

      // Reset during data bit 3 of 0xFF with two bytes queued.
      push_byte(8'hFF);
      push_byte(8'h11);
      push_byte(8'h22);
      repeat (4 * CPB + 1) @(negedge CLK);
      check("pre_reset_busy", tx_busy, 1);
      check("pre_reset_tx", TX, 1);
      rst = 1'b1;
      @(negedge CLK);
      rst = 1'b0;
      check("abort_tx", TX, 1);
      check("abort_busy", tx_busy, 0);
      check("abort_ready", tx_ready, 1);
      repeat (30 * CPB) @(negedge CLK);
      check("after_abort_tx", TX, 1);
      check("after_abort_busy", tx_busy, 0);

      check("scoreboard_drained", exp_q.size(), 0);
      check("monitor_idle", mon_in_frame, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
